sqrt_calculator: RTL and testbench



---
 rtl/sqrt_pkg.sv | 15 +
 rtl/sqrt_step.sv | 24 ++
 rtl/sqrt_calculator.sv | 85 ++++++++
 tb/tb_sqrt_calculator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/sqrt_pkg.sv
// Shared widths, iteration count and FSM encoding for the integer square-root unit.
package sqrt_pkg;
    localparam int SQRT_IN_W    = 16;
    localparam int SQRT_OUT_W   = 8;
    localparam int SQRT_ITER    = 8;
    localparam int SQRT_CNT_W   = $clog2(SQRT_ITER);
    localparam int SQRT_REM_W   = 11;
    localparam int SQRT_TRIAL_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } sqrt_state_t;
endpackage

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration; consumes two radicand bits.
// Purely combinational, zero latency; no flow control.
module sqrt_step
    import sqrt_pkg::*;
(
    input  logic [SQRT_REM_W-1:0] rem,
    input  logic [1:0]            bits,
    input  logic [SQRT_OUT_W-1:0] root,
    output logic [SQRT_REM_W-1:0] rem_nxt,
    output logic [SQRT_OUT_W-1:0] root_nxt
);
    logic [SQRT_REM_W-1:0]   rem_sh;
    logic [SQRT_TRIAL_W-1:0] trial;
    logic                    fits;

    // rem never exceeds 2*root, so its top two bits are always zero before the shift.
    always_comb begin
        rem_sh   = {rem[SQRT_REM_W-3:0], bits};
        trial    = {root, 2'b01};
        fits     = rem_sh >= SQRT_REM_W'(trial);
        rem_nxt  = fits ? rem_sh - SQRT_REM_W'(trial) : rem_sh;
        root_nxt = {root[SQRT_OUT_W-2:0], fits};
    end
endmodule

// File: rtl/sqrt_calculator.sv
// Multi-cycle floor(sqrt) of a 16-bit radicand to an 8-bit root, one done strobe per result.
// Latency 9 cycles from the accepting edge; a start while busy is dropped and pulses error.
// SQRT_SIGNED_CHECK_EN: negative two's-complement inputs finish next cycle with out=0, error=1.
module sqrt_calculator
    import sqrt_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SQRT_IN_W-1:0]  in,
    output logic [SQRT_OUT_W-1:0] out,
    output logic                  error,
    output logic                  done
);
    sqrt_state_t           state;
    logic [SQRT_IN_W-1:0]  rad;
    logic [SQRT_REM_W-1:0] rem;
    logic [SQRT_OUT_W-1:0] root;
    logic [SQRT_CNT_W-1:0] cnt;
    logic                  neg;
    logic                  neg_in;
    logic [SQRT_REM_W-1:0] rem_nxt;
    logic [SQRT_OUT_W-1:0] root_nxt;

`ifdef SQRT_SIGNED_CHECK_EN
    assign neg_in = in[SQRT_IN_W-1];
`else
    assign neg_in = 1'b0;
`endif

    sqrt_step u_step (
        .rem      (rem),
        .bits     (rad[SQRT_IN_W-1:SQRT_IN_W-2]),
        .root     (root),
        .rem_nxt  (rem_nxt),
        .root_nxt (root_nxt)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            rad   <= '0;
            rem   <= '0;
            root  <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            out   <= '0;
            error <= 1'b0;
            done  <= 1'b0;
        end else begin
            error <= 1'b0;
            done  <= 1'b0;
            // Result publication; a rejected negative request leaves root at 0.
            if (state == DONE) begin
                out   <= root;
                done  <= 1'b1;
                error <= neg;
            end
            case (state)
                CALC: begin
                    rem  <= rem_nxt;
                    root <= root_nxt;
                    rad  <= {rad[SQRT_IN_W-3:0], 2'b00};
                    cnt  <= cnt - 1'b1;
                    if (cnt == '0)
                        state <= DONE;
                    if (start)
                        error <= 1'b1;
                end
                default: begin
                    if (start) begin
                        rad   <= in;
                        rem   <= '0;
                        root  <= '0;
                        cnt   <= SQRT_CNT_W'(SQRT_ITER - 1);
                        neg   <= neg_in;
                        state <= neg_in ? DONE : CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sqrt_calculator.sv
// Directed bench with a result scoreboard for sqrt_calculator.
module tb_sqrt_calculator;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] in = '0;
    logic [7:0]  out;
    logic        error;
    logic        done;

    typedef struct {
        int res;
        int due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   err_due = -1;
    int   vectors = 0;
    int   miscompares = 0;
    bit   mon_en = 1'b0;

    sqrt_calculator dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .in    (in),
        .out   (out),
        .error (error),
        .done  (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Caller sits at a negedge; start is accepted at the next posedge.
    task automatic issue(input logic [15:0] v);
        exp_t e;
        start = 1'b1;
        in    = v;
        e.res = isqrt(int'(v));
        e.due = cyc + 10;
`ifdef SQRT_SIGNED_CHECK_EN
        if (v[15]) begin
            e.res   = 0;
            e.due   = cyc + 2;
            err_due = cyc + 2;
        end
`endif
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        vectors++;
        assert (sb.size() === 0) else begin
            miscompares++;
            $error("FAIL timeout pending=%0d required=0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            assert (error === (cyc == err_due)) else begin
                miscompares++;
                $error("FAIL error_pulse cyc=%0d got=%b required=%b", cyc, error, cyc == err_due);
            end
            if (done === 1'b1) begin
                vectors++;
                assert (sb.size() !== 0) else begin
                    miscompares++;
                    $error("FAIL unexpected_done cyc=%0d out=%0d", cyc, out);
                end
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    vectors += 2;
                    assert (int'(out) === e.res) else begin
                        miscompares++;
                        $error("FAIL result got=%0d required=%0d", out, e.res);
                    end
                    assert (cyc === e.due) else begin
                        miscompares++;
                        $error("FAIL latency done_cyc=%0d required=%0d", cyc, e.due);
                    end
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        vectors += 3;
        assert (out === 8'd0) else begin miscompares++; $error("FAIL rst_out got=%0d required=0", out); end
        assert (error === 1'b0) else begin miscompares++; $error("FAIL rst_error got=%b required=0", error); end
        assert (done === 1'b0) else begin miscompares++; $error("FAIL rst_done got=%b required=0", done); end
        rst = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);

        issue(16'd0);     wait_idle();
        issue(16'd65535); wait_idle();
        issue(16'd144);   wait_idle();
        issue(16'd200);   wait_idle();
        issue(16'd1);     wait_idle();

        // Back-to-back issue: second start lands on the edge that publishes the first.
        @(negedge clk);
        issue(16'd144);
        repeat (8) @(negedge clk);
        issue(16'd200);
        wait_idle();

        // Start while busy at E3 is dropped and flagged.
        @(negedge clk);
        issue(16'd10000);
        repeat (2) @(negedge clk);
        start   = 1'b1;
        in      = 16'd4;
        err_due = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);

        // Reset at E4 aborts the computation and clears the output.
        issue(16'd900);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        vectors += 2;
        assert (out === 8'd0) else begin miscompares++; $error("FAIL abort_out got=%0d required=0", out); end
        assert (done === 1'b0) else begin miscompares++; $error("FAIL abort_done got=%b required=0", done); end
        rst = 1'b1;
        repeat (12) @(negedge clk);
        issue(16'd900); wait_idle();

        for (int i = 0; i < 90; i++) begin
            issue(16'd0);
            repeat (11) @(negedge clk);
        end
        wait_idle();

        for (int i = 0; i < 8; i++) begin
            issue(16'($urandom_range(0, 65535)));
            wait_idle();
        end

`ifdef SQRT_SIGNED_CHECK_EN
        @(negedge clk);
        issue(16'h8000); wait_idle();
        issue(16'd49);   wait_idle();
`endif

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
